fp_divider: RTL
===============

Name: fp_divider

Overview:
- Iterative floating-point divider producing a / b. It sits alongside the pipelined FP multiplier in the arithmetic unit and uses the same field-level operand format, mode select and flag set.
- A start/busy/done handshake replaces the fixed pipeline.
- The mantissa quotient comes from a restoring radix-2 divider, one bit per cycle. Rounding and packing then follow, with half-precision range checks done in internal SP-biased exponent format.

Parameters:
- ITER, 26, number of quotient bits: 1 integer bit, 23 fraction bits, normalization slack and guard.
- SP_BIAS, 127, single-precision exponent bias.
- HP_BIAS, 15, half-precision exponent bias.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- mode_fp  in  1  0 = half precision, 1 = single precision
- round_mode  in  1  0 = truncate, 1 = round-to-nearest-even
- sign_a, sign_b  in  1  operand signs
- exp_a, exp_b  in  8  SP-biased exponents (internal format in both modes)
- mant_a, mant_b  in  23  fractions, implicit 1
- busy  out  1  high from the sampling edge until done
- done  out  1  one-cycle pulse when results are valid
- result_sign  out  1  sign_a ^ sign_b
- result_exp  out  8  internal SP-biased exponent
- result_mant  out  23  fraction
- overflow, underflow, inexact, div_by_zero  out  1  exception flags

Behaviour:
- Reset (async, any state, including mid-division): state IDLE; every output and internal register = 0.
- FSM states: IDLE, DIV, PACK.
- IDLE, start=1 at edge E0:
  - Latch all inputs and the dividend/divisor {1,mant}.
  - Compute exp_diff = exp_a - exp_b + SP_BIAS as signed 10-bit.
  - Set busy=1 and go to DIV, or to PACK on a special case.
- start while busy: ignored. Input changes after E0 have no effect.
- DIV:
  - One restoring step per edge: rem = (rem<<1) - divisor if non-negative, else keep; shift the quotient bit into q.
  - After ITER edges, go to PACK.
- PACK (one edge): round, range-check, register results; done=1 and busy=0 for exactly one cycle; then IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge E0+ITER+1, i.e. 27 edges after sampling with the default ITER.
  - Special case: done is high after edge E0+1.
- Outputs hold their values until the next done or reset. A new start may be issued in the cycle done is high, because state is already IDLE.
- Normalize, with q[25] as the 2^0 bit:
  - If q[25]=1: frac = q[24:2], guard = q[1], sticky = q[0] | (rem≠0), exponent = exp_diff.
  - Else: frac = q[23:1], guard = q[0], sticky = (rem≠0), exponent = exp_diff - 1.
- Half-precision rounding point:
  - Rounding happens at frac bit 13.
  - Guard becomes frac[12]; sticky ORs in frac[11:0] and the SP guard/sticky.
  - result_mant[12:0] is forced to 0.
- Rounding:
  - RNE rounds up iff guard & (sticky | lsb). Truncate never rounds up.
  - A carry out of the fraction gives frac = 0 and exponent + 1.
  - inexact = guard | sticky.
- Range check, SP mode:
  - Exponent ≤ 0: underflow = 1, exp = 0, mant = 0.
  - Exponent ≥ 255: overflow = 1, exp = 0xFF, mant = 0.
- Range check, HP mode:
  - Compute hp = exponent - SP_BIAS + HP_BIAS.
  - hp ≤ 0: underflow, zero result.
  - hp ≥ 31: overflow, exp = 0xFF, mant = 0.
  - Otherwise result_exp = exponent, unchanged in SP-biased form.
- Overflow or underflow also sets inexact = 1.
- Special cases (exp = 0 means zero; no denormal support; exp = 0xFF means infinity, mant ignored):
  - b = 0, a ≠ 0: div_by_zero = 1; result exp 0xFF, mant 0.
  - 0/0 or inf/inf: NaN, exp 0xFF, mant 0x400000; no flags.
  - a = 0 or b = inf: zero, exp 0, mant 0.
  - a = inf: exp 0xFF, mant 0.
  - In all special cases result_sign is still sign_a ^ sign_b.

Decomposition:
- Shared package fp_pkg:
  - Constants SP_BIAS, HP_BIAS, SP_EXP_MAX = 8'hFF, HP_EXP_MAX = 5'h1F, QNAN_MANT = 23'h400000.
  - FSM state typedef.
  - Rounding-mode encodings.
- One natural sub-module: fp_round_pack. It is combinational: normalize, round, range-check and flags. Both fp_divider and a later multiplier revision reuse it.

Test Plan:
- SP 6.0/2.0: a = (0, 129, 0x400000), b = (0, 128, 0). Expected: done at edge 27 with exp 128, mant 0x400000, all flags 0.
- SP 1.0/3.0: a = (0, 127, 0), b = (0, 128, 0x400000).
  - RNE: exp 125, mant 0x2AAAAB, inexact 1.
  - round_mode = 0: mant 0x2AAAAA.
  - HP truncate: mant 0x2AA000.
- Division by zero: a = 1.0, b exp 0. Expected: done after 2 edges, exp 0xFF, mant 0, div_by_zero 1. A 0/0 case gives mant 0x400000.
- Range limits:
  - SP overflow: exp_a 254, exp_b 1. Expected: overflow 1, exp 0xFF.
  - SP underflow: exp_a 1, exp_b 254. Expected: underflow 1, exp 0.
  - HP overflow: exp_a 137, exp_b 121, hp = 31. Expected: overflow 1.
- Handshake: start pulsed again at edges 5 and 10 with different operands. Expected: ignored, first result unchanged. A back-to-back start in the done cycle is accepted.
- Reset: assert rst at edge 12 of a division. Expected: all outputs 0 immediately (async). After release, the next start yields a correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP arithmetic definitions: biases, exponent limits, FSM states,
// rounding-mode encodings and special-case classes.
package fp_pkg;
    localparam int          SP_BIAS    = 127;
    localparam int          HP_BIAS    = 15;
    localparam logic [7:0]  SP_EXP_MAX = 8'hFF;
    localparam logic [4:0]  HP_EXP_MAX = 5'h1F;
    localparam logic [22:0] QNAN_MANT  = 23'h400000;

    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_PACK} fsm_state_t;

    typedef enum logic {RND_TRUNC = 1'b0, RND_RNE = 1'b1} rnd_mode_t;

    typedef enum logic [2:0] {SPC_NONE, SPC_DBZ, SPC_NAN, SPC_ZERO, SPC_INF} spc_kind_t;
endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalize / round / range-check / flag stage for a 26-bit
// quotient (bit 25 = 2^0) with SP-biased exponent; HP mode rounds at frac bit 13.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int SP_BIAS = fp_pkg::SP_BIAS,
    parameter int HP_BIAS = fp_pkg::HP_BIAS
) (
    input  logic              i_mode_fp,
    input  logic              i_round_mode,
    input  logic [25:0]       i_q,
    input  logic              i_rem_nz,
    input  logic signed [9:0] i_exp,
    output logic [7:0]        o_exp,
    output logic [22:0]       o_mant,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_inexact
);
    localparam logic signed [9:0] HP_OFS = 10'(SP_BIAS - HP_BIAS);
    localparam logic signed [9:0] SP_TOP = $signed({2'b00, SP_EXP_MAX});
    localparam logic signed [9:0] HP_TOP = $signed({5'b00000, HP_EXP_MAX});

    function automatic logic round_up(input logic rnd, input logic g,
                                      input logic s, input logic lsb);
        return (rnd == RND_RNE) && g && (s || lsb);
    endfunction

    logic [22:0]       w_frac;
    logic              w_guard;
    logic              w_sticky;
    logic              w_lsb;
    logic              w_up;
    logic [23:0]       w_inc;
    logic [23:0]       w_sum;
    logic signed [9:0] w_exp_n;
    logic signed [9:0] w_exp_r;
    logic signed [9:0] w_hp;
    logic              w_ovf;
    logic              w_unf;

    always_comb begin
        w_frac   = i_q[23:1];
        w_guard  = i_q[0];
        w_sticky = i_rem_nz;
        w_exp_n  = i_exp - 10'sd1;
        if (i_q[25]) begin
            w_frac   = i_q[24:2];
            w_guard  = i_q[1];
            w_sticky = i_q[0] | i_rem_nz;
            w_exp_n  = i_exp;
        end

        w_lsb = w_frac[0];
        w_inc = 24'd1;
        if (!i_mode_fp) begin
            // Move the rounding point down to the 10-bit HP fraction.
            w_sticky     = w_sticky | w_guard | (|w_frac[11:0]);
            w_guard      = w_frac[12];
            w_lsb        = w_frac[13];
            w_frac[12:0] = '0;
            w_inc        = 24'h002000;
        end

        w_up    = round_up(i_round_mode, w_guard, w_sticky, w_lsb);
        w_sum   = {1'b0, w_frac} + (w_up ? w_inc : 24'd0);
        w_exp_r = w_sum[23] ? (w_exp_n + 10'sd1) : w_exp_n;
        w_hp    = w_exp_r - HP_OFS;

        if (i_mode_fp) begin
            w_unf = (w_exp_r <= 10'sd0);
            w_ovf = (w_exp_r >= SP_TOP);
        end else begin
            w_unf = (w_hp <= 10'sd0);
            w_ovf = (w_hp >= HP_TOP);
        end

        // On carry-out the fraction bits of w_sum are already zero.
        o_exp  = w_exp_r[7:0];
        o_mant = w_sum[22:0];
        if (w_ovf) begin
            o_exp  = SP_EXP_MAX;
            o_mant = '0;
        end else if (w_unf) begin
            o_exp  = '0;
            o_mant = '0;
        end
        o_overflow  = w_ovf;
        o_underflow = w_unf && !w_ovf;
        o_inexact   = w_guard | w_sticky | w_ovf | w_unf;
    end
endmodule

// File: rtl/fp_divider.sv
// Iterative FP divider: restoring radix-2 mantissa division, one quotient bit
// per cycle, followed by a single round/pack cycle with start/busy/done handshake.
module fp_divider
    import fp_pkg::*;
#(
    parameter int ITER    = 26,
    parameter int SP_BIAS = fp_pkg::SP_BIAS,
    parameter int HP_BIAS = fp_pkg::HP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [22:0] mant_a,
    input  logic [22:0] mant_b,
    output logic        busy,
    output logic        done,
    output logic        result_sign,
    output logic [7:0]  result_exp,
    output logic [22:0] result_mant,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        div_by_zero
);
    localparam int CW = $clog2(ITER);
    localparam logic signed [9:0] BIAS10 = 10'(SP_BIAS);

    fsm_state_t        r_state;
    spc_kind_t         r_spec;
    logic [CW-1:0]     r_cnt;
    logic              r_mode;
    logic              r_rnd;
    logic              r_sign;
    logic [23:0]       r_divisor;
    logic [24:0]       r_rem;
    logic [ITER-1:0]   r_q;
    logic signed [9:0] r_exp_diff;
    logic              r_busy;
    logic              r_done;
    logic              r_res_sign;
    logic [7:0]        r_res_exp;
    logic [22:0]       r_res_mant;
    logic              r_ovf;
    logic              r_unf;
    logic              r_inx;
    logic              r_dbz;

    spc_kind_t         w_spec;
    logic signed [9:0] w_exp_diff;
    logic [25:0]       w_trial;
    logic              w_qbit;
    logic [24:0]       w_rem_sel;
    logic [7:0]        w_rp_exp;
    logic [22:0]       w_rp_mant;
    logic              w_rp_ovf;
    logic              w_rp_unf;
    logic              w_rp_inx;

    always_comb begin
        w_spec = SPC_NONE;
        if (((exp_a == 8'd0) && (exp_b == 8'd0)) ||
            ((exp_a == SP_EXP_MAX) && (exp_b == SP_EXP_MAX)))
            w_spec = SPC_NAN;
        else if (exp_b == 8'd0)
            w_spec = SPC_DBZ;
        else if ((exp_a == 8'd0) || (exp_b == SP_EXP_MAX))
            w_spec = SPC_ZERO;
        else if (exp_a == SP_EXP_MAX)
            w_spec = SPC_INF;
    end

    assign w_exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS10;

    // Restoring step: subtract when the partial remainder covers the divisor.
    assign w_trial   = {1'b0, r_rem} - {2'b00, r_divisor};
    assign w_qbit    = ~w_trial[25];
    assign w_rem_sel = w_qbit ? w_trial[24:0] : r_rem;

    fp_round_pack #(
        .SP_BIAS(SP_BIAS),
        .HP_BIAS(HP_BIAS)
    ) u_round_pack (
        .i_mode_fp   (r_mode),
        .i_round_mode(r_rnd),
        .i_q         (r_q),
        .i_rem_nz    (|r_rem),
        .i_exp       (r_exp_diff),
        .o_exp       (w_rp_exp),
        .o_mant      (w_rp_mant),
        .o_overflow  (w_rp_ovf),
        .o_underflow (w_rp_unf),
        .o_inexact   (w_rp_inx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_spec     <= SPC_NONE;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_rnd      <= 1'b0;
            r_sign     <= 1'b0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_exp_diff <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res_sign <= 1'b0;
            r_res_exp  <= '0;
            r_res_mant <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_spec     <= w_spec;
                        r_mode     <= mode_fp;
                        r_rnd      <= round_mode;
                        r_sign     <= sign_a ^ sign_b;
                        r_divisor  <= {1'b1, mant_b};
                        r_rem      <= {2'b01, mant_a};
                        r_q        <= '0;
                        r_cnt      <= '0;
                        r_exp_diff <= w_exp_diff;
                        r_busy     <= 1'b1;
                        r_state    <= (w_spec == SPC_NONE) ? ST_DIV : ST_PACK;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_sel << 1;
                    r_q   <= {r_q[ITER-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER - 1))
                        r_state <= ST_PACK;
                end
                ST_PACK: begin
                    r_res_sign <= r_sign;
                    r_res_exp  <= SP_EXP_MAX;
                    r_res_mant <= '0;
                    r_ovf      <= 1'b0;
                    r_unf      <= 1'b0;
                    r_inx      <= 1'b0;
                    r_dbz      <= 1'b0;
                    case (r_spec)
                        SPC_DBZ:  r_dbz      <= 1'b1;
                        SPC_NAN:  r_res_mant <= QNAN_MANT;
                        SPC_ZERO: r_res_exp  <= '0;
                        SPC_INF:  r_res_exp  <= SP_EXP_MAX;
                        default: begin
                            r_res_exp  <= w_rp_exp;
                            r_res_mant <= w_rp_mant;
                            r_ovf      <= w_rp_ovf;
                            r_unf      <= w_rp_unf;
                            r_inx      <= w_rp_inx;
                        end
                    endcase
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_sign = r_res_sign;
    assign result_exp  = r_res_exp;
    assign result_mant = r_res_mant;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign inexact     = r_inx;
    assign div_by_zero = r_dbz;
endmodule
